// File: rtl/melody_play_ctrl.sv
// rtl/melody_play_ctrl.sv - melody note buffer with timed note/gap playback onto the piezo driver
module melody_play_ctrl #(
  parameter int NOTE_TICKS = 5000000,
  parameter int GAP_TICKS  = 500000,
  parameter int DEPTH      = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_note_valid,
  input  logic [3:0] i_note_code,
  input  logic       i_clear,
  input  logic       i_play_req,
  input  logic [2:0] i_rd_index,
  output logic [3:0] o_rd_data,
  output logic [3:0] o_note_count,
  output logic       o_full,
  output logic       o_overflow,
  output logic       o_play_busy,
  output logic       o_play_done,
  output logic       o_piezo_en,
  output logic [3:0] o_piezo_code
);

  localparam int MAXT = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [3:0]    DEPTH_C   = 4'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NOTE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [3:0]    r_buf [0:DEPTH-1];
  logic [3:0]    r_count;
  logic [1:0]    r_state;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_timer;
  logic          r_overflow;
  logic          r_done;
  logic [3:0]    r_piezo_code;

  logic          w_full;
  logic          w_last;
  logic [2:0]    w_next_idx;
  logic [3:0]    w_next_code;

  assign w_full      = (r_count == DEPTH_C);
  assign w_last      = ({1'b0, r_idx} == (r_count - 4'd1));
  assign w_next_idx  = r_idx + 3'd1;
  assign w_next_code = r_buf[w_next_idx[AW-1:0]];

  // Entries at or beyond the fill level read as rest, so clear never has to wipe storage.
  assign o_rd_data    = ({1'b0, i_rd_index} < r_count) ? r_buf[i_rd_index[AW-1:0]] : 4'd0;
  assign o_note_count = r_count;
  assign o_full       = w_full;
  assign o_overflow   = r_overflow;
  assign o_play_busy  = (r_state != ST_IDLE);
  assign o_play_done  = r_done;
  assign o_piezo_en   = (r_state == ST_NOTE) && (r_piezo_code != 4'd0);
  assign o_piezo_code = r_piezo_code;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= 4'd0;
      r_count      <= 4'd0;
      r_state      <= ST_IDLE;
      r_idx        <= 3'd0;
      r_timer      <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
      r_piezo_code <= 4'd0;
    end else begin
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_clear) begin
            r_count <= 4'd0;
          end else if (i_play_req) begin
            if (r_count == 4'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state      <= ST_NOTE;
              r_idx        <= 3'd0;
              r_timer      <= '0;
              r_piezo_code <= r_buf[0];
            end
          end else if (i_note_valid) begin
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_buf[r_count[AW-1:0]] <= i_note_code;
              r_count                <= r_count + 4'd1;
            end
          end
        end
        ST_NOTE, ST_GAP: begin
          if (i_clear) begin
            r_state      <= ST_IDLE;
            r_count      <= 4'd0;
            r_timer      <= '0;
            r_piezo_code <= 4'd0;
          end else if ((r_state == ST_NOTE && r_timer == NOTE_LAST) ||
                       (r_state == ST_GAP  && r_timer == GAP_LAST)) begin
            r_timer <= '0;
            if (r_state == ST_NOTE && GAP_TICKS > 0) begin
              r_state <= ST_GAP;
            end else if (w_last) begin
              r_state      <= ST_IDLE;
              r_done       <= 1'b1;
              r_piezo_code <= 4'd0;
            end else begin
              r_state      <= ST_NOTE;
              r_idx        <= w_next_idx;
              r_piezo_code <= w_next_code;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
